// File: rtl/gal16v8_demo_input_stepper.sv
// Input stepper for the GAL16V8 gate demo: debounces two buttons and walks {a,b}
// through 00->01->11->10 either on step presses or on a fixed auto-mode cadence.

module gal16v8_btn_dbnc #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_rise
);
    logic [1:0]       r_sync;
    logic             r_deb;
    logic             r_deb_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sample;

    assign w_sample = r_sync[1];

    // A new level is taken only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_deb_q <= r_deb;
            if (w_sample == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_deb <= w_sample;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_rise = r_deb & ~r_deb_q;
endmodule

module gal16v8_demo_input_stepper #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_DIV        = 8,
    parameter int CNT_W           = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_step,
    input  logic i_btn_mode,
    output logic o_a,
    output logic o_b,
    output logic o_auto_mode,
    output logic o_step_pulse
);
    localparam int NUM_BTN = 2;

    logic [NUM_BTN-1:0] w_btn;
    logic [NUM_BTN-1:0] w_rise;
    logic [CNT_W-1:0]   r_pre;
    logic               w_wrap;
    logic               w_adv;

    assign w_btn = {i_btn_mode, i_btn_step};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        gal16v8_btn_dbnc #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_dbnc (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_btn  (w_btn[g]),
            .o_rise (w_rise[g])
        );
    end

    // Advance decision uses the mode in force before this edge.
    assign w_wrap = (r_pre == CNT_W'(AUTO_DIV - 1));
    assign w_adv  = o_auto_mode ? w_wrap : w_rise[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_a          <= 1'b0;
            o_b          <= 1'b0;
            o_auto_mode  <= 1'b0;
            o_step_pulse <= 1'b0;
            r_pre        <= '0;
        end else begin
            o_step_pulse <= w_adv;
            // Gray successor of {a,b}: next = {b, ~a}.
            if (w_adv) begin
                o_a <= o_b;
                o_b <= ~o_a;
            end
            if (w_rise[1]) begin
                o_auto_mode <= ~o_auto_mode;
                r_pre       <= '0;
            end else if (!o_auto_mode || w_wrap) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_gal16v8_demo_input_stepper.sv
// Directed bench for the GAL16V8 input stepper: reset, manual walk, bounce,
// auto stepping, mode/advance collision and a downstream gate truth-table check.

module tb_gal16v8_demo_input_stepper;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic btn_step = 1'b0;
    logic btn_mode = 1'b0;
    logic a, b, auto_mode, step_pulse;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [1:0] exp_ab = 2'b00;

    always #5 clk = ~clk;

    gal16v8_demo_input_stepper #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_DIV       (8),
        .CNT_W          (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn_step  (btn_step),
        .i_btn_mode  (btn_mode),
        .o_a         (a),
        .o_b         (b),
        .o_auto_mode (auto_mode),
        .o_step_pulse(step_pulse)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (step_pulse) pulses++;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Hand-written truth table of {m1..m6} = {XOR, NOR, NAND, AND, OR, NOT a}.
    function automatic logic [5:0] gate_exp(input logic [1:0] s);
        case (s)
            2'b00:   return 6'b011001;
            2'b01:   return 6'b101011;
            2'b10:   return 6'b101010;
            default: return 6'b000110;
        endcase
    endfunction

    function automatic logic [5:0] demo(input logic ia, input logic ib);
        return {ia ^ ib, ~(ia | ib), ~(ia & ib), ia & ib, ia | ib, ~ia};
    endfunction

    task automatic chk_step(input string tag);
        exp_ab = nxt(exp_ab);
        chk({tag, "_pulse"}, int'(step_pulse), 1);
        chk({tag, "_ab"}, int'({a, b}), int'(exp_ab));
        chk({tag, "_gates"}, int'(demo(a, b)), int'(gate_exp(exp_ab)));
    endtask

    task automatic manual_press(input string tag);
        int p0;
        p0 = pulses;
        btn_step = 1'b1;
        tick(6);
        chk({tag, "_early"}, int'(step_pulse), 0);
        tick(1);
        chk_step(tag);
        tick(1);
        chk({tag, "_one_cycle"}, int'(step_pulse), 0);
        tick(12);
        btn_step = 1'b0;
        tick(20);
        chk({tag, "_count"}, pulses - p0, 1);
    endtask

    task automatic wait_mode(input string tag, input logic lvl);
        int found;
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            tick(1);
            if (auto_mode == lvl) found = i;
        end
        chk({tag, "_lat"}, found, 7);
    endtask

    initial begin
        int p0;
        int bnc[15] = '{1, 3, 2, 1, 3, 2, 3, 1, 2, 3, 1, 2, 3, 2, 1};

        // Reset state
        #2 rst_n = 1'b0;
        tick(3);
        chk("rst_hold", int'({a, b, auto_mode, step_pulse}), 0);
        rst_n = 1'b1;
        tick(3);
        chk("rst_idle", int'({a, b, auto_mode, step_pulse}), 0);
        chk("rst_nopulse", pulses, 0);

        // Manual walk
        manual_press("walk1");
        manual_press("walk2");
        manual_press("walk3");
        manual_press("walk4");

        // Bounce then stable high: single advance
        p0 = pulses;
        for (int i = 0; i < 15; i++) begin
            btn_step = (i % 2 == 0);
            tick(bnc[i]);
        end
        chk("bnc_none_yet", pulses - p0, 0);
        tick(20);
        exp_ab = nxt(exp_ab);
        chk("bnc_count", pulses - p0, 1);
        chk("bnc_ab", int'({a, b}), int'(exp_ab));
        btn_step = 1'b0;
        tick(20);

        // Short pulse below debounce threshold
        p0 = pulses;
        btn_step = 1'b1;
        tick(3);
        btn_step = 1'b0;
        tick(20);
        chk("short_count", pulses - p0, 0);
        chk("short_ab", int'({a, b}), int'(exp_ab));

        // Async reset mid-press, then a press held through release
        p0 = pulses;
        btn_step = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #2;
        chk("async_rst", int'({a, b, auto_mode, step_pulse}), 0);
        exp_ab = 2'b00;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("rel_early", int'(step_pulse), 0);
        tick(1);
        chk_step("rel_step");
        tick(1);
        chk("rel_one_cycle", int'(step_pulse), 0);
        tick(12);
        chk("rel_count", pulses - p0, 1);
        btn_step = 1'b0;
        tick(20);

        // Auto mode: step every 8 cycles, step button ignored
        btn_mode = 1'b1;
        wait_mode("auto_on", 1'b1);
        btn_mode = 1'b0;
        chk("auto_on", int'(auto_mode), 1);
        p0 = pulses;
        for (int s = 0; s < 16; s++) begin
            if (s == 3) btn_step = 1'b1;
            if (s == 6) btn_step = 1'b0;
            tick(4);
            chk("auto_mid", int'(step_pulse), 0);
            tick(4);
            chk_step("auto");
        end
        chk("auto_count", pulses - p0, 16);

        // Leave auto mode right after a step: no extra advance
        btn_mode = 1'b1;
        wait_mode("auto_off", 1'b0);
        btn_mode = 1'b0;
        p0 = pulses;
        tick(30);
        chk("off_count", pulses - p0, 0);
        chk("off_ab", int'({a, b}), int'(exp_ab));
        chk("off_mode", int'(auto_mode), 0);

        // Mode rise coincident with prescaler wrap
        btn_mode = 1'b1;
        wait_mode("auto_on2", 1'b1);
        btn_mode = 1'b0;
        tick(8);
        chk_step("auto2");
        tick(1);
        btn_mode = 1'b1;
        tick(6);
        chk("coll_pre", int'({auto_mode, step_pulse}), 2);
        tick(1);
        chk_step("coll");
        chk("coll_mode", int'(auto_mode), 0);
        btn_mode = 1'b0;
        p0 = pulses;
        tick(30);
        chk("coll_after", pulses - p0, 0);
        chk("coll_ab", int'({a, b}), int'(exp_ab));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
